// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps between digits.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks a zero high digit.
module seven_seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_value,
    input  logic       i_load,
    input  logic       i_en,
    output logic [6:0] o_digitalTube,
    output logic       o_sel,
    output logic       o_frame_tick
);

    localparam int MAXN = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BLK1 = 2'd0,
        S_LO   = 2'd1,
        S_BLK0 = 2'd2,
        S_HI   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic          sel_q, sel_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] last;
    logic [3:0]    nib_d;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] f;
        unique case (n)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            4'hF: f = 7'h0E;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        last    = BLANK_LAST;
        if (state_q == S_LO || state_q == S_HI) begin
            last = SCAN_LAST;
        end
        if (cnt_q == last) begin
            cnt_d = '0;
            unique case (state_q)
                S_BLK1:  state_d = S_LO;
                S_LO:    state_d = S_BLK0;
                S_BLK0:  state_d = S_HI;
                S_HI:    state_d = S_BLK1;
                default: state_d = S_BLK1;
            endcase
        end

        disp_d = i_load ? i_value : disp_q;
        nib_d  = (state_d == S_HI) ? disp_d[7:4] : disp_d[3:0];

        // Outputs derive from next-state values so they align with the state register.
        seg_d = 7'h7F;
        if (i_en && (state_d == S_LO || state_d == S_HI)) begin
            seg_d = hex_font(nib_d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (state_d == S_HI && nib_d == 4'h0) begin
                seg_d = 7'h7F;
            end
`endif
        end
        sel_d  = (state_d == S_BLK0 || state_d == S_HI);
        tick_d = (state_d == S_LO) && (state_q != S_LO);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_BLK1;
            cnt_q   <= '0;
            disp_q  <= 8'h00;
            seg_q   <= 7'h7F;
            sel_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    assign o_digitalTube = seg_q;
    assign o_sel         = sel_q;
    assign o_frame_tick  = tick_q;

endmodule
